inv_atm_light_te: RTL and testbench

INV_ATM_LIGHT_TE -- requirements
Module: inv_atm_light_te

---
 rtl/inv_atm_light_te_pkg.sv | 25 ++
 rtl/inv_atm_light_te_div_step.sv | 17 +
 rtl/inv_atm_light_te.sv | 123 ++++++++++++
 tb/tb_inv_atm_light_te.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/inv_atm_light_te_pkg.sv
// Shared constants and FSM encoding for the inverse atmospheric light unit.
package inv_atm_light_te_pkg;

    localparam int INV_W      = 10;
    localparam int PIX_W      = 8;
    localparam int REM_W      = 9;
    localparam int DIV_ITERS  = 10;
    localparam int DIVIDEND   = 65536;
    localparam int SAT_VAL    = 1023;
    localparam int SAT_THRESH = 64;

    // Dividend bits above the quotient field; the low DIV_ITERS dividend bits are all zero.
    localparam int REM_INIT   = DIVIDEND >> DIV_ITERS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Channels at or below the threshold (including zero) cannot fit the quotient field.
    function automatic logic is_sat(input logic [PIX_W-1:0] a);
        return a <= PIX_W'(SAT_THRESH);
    endfunction

endpackage

// File: rtl/inv_atm_light_te_div_step.sv
// One restoring-division step: shift in a zero dividend bit, compare, conditionally subtract.
module div_step_te
    import inv_atm_light_te_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [PIX_W-1:0] divisor,
    output logic [REM_W-1:0] rem_next,
    output logic             q_bit
);

    logic [REM_W:0] shifted;

    assign shifted  = {rem, 1'b0};
    assign q_bit    = shifted >= {2'b00, divisor};
    assign rem_next = REM_W'(q_bit ? shifted - {2'b00, divisor} : shifted);

endmodule

// File: rtl/inv_atm_light_te.sv
// Inverse atmospheric light: Inv = min(1023, 65536/A) per channel, bit-serial,
// R then G then B, constant 34-edge latency.
// Build option: define INV_AC_ROUND_EN to round half-up instead of truncating.
module inv_atm_light_te
    import inv_atm_light_te_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] A_R,
    input  logic [PIX_W-1:0] A_G,
    input  logic [PIX_W-1:0] A_B,
    output logic [INV_W-1:0] Inv_AR,
    output logic [INV_W-1:0] Inv_AG,
    output logic [INV_W-1:0] Inv_AB,
    output logic             busy,
    output logic             done,
    output logic [2:0]       div_sat
);

    logic [1:0]                  state;
    logic [1:0]                  ch;
    logic [3:0]                  it_cnt;
    logic [2:0][PIX_W-1:0]       a_cap;
    logic [REM_W-1:0]            rem;
    logic [INV_W-1:0]            quo;
    logic                        sat_cur;
    logic [1:0][INV_W-1:0]       res_hold;
    logic [1:0]                  sat_hold;

    logic [PIX_W-1:0]            cur_a;
    logic [REM_W-1:0]            rem_next;
    logic                        q_bit;
    logic [3:0]                  bit_idx;
    logic [INV_W-1:0]            quo_next;
    logic [INV_W-1:0]            fin_q;
    logic [INV_W-1:0]            ch_result;

    assign cur_a   = a_cap[ch];
    assign bit_idx = 4'(DIV_ITERS - 1) - it_cnt;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    div_step_te u_step (
        .rem      (rem),
        .divisor  (cur_a),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Place this cycle's quotient bit (MSB first) and form the channel result.
    always_comb begin
        quo_next          = quo;
        quo_next[bit_idx] = q_bit;
        fin_q             = quo_next;
`ifdef INV_AC_ROUND_EN
        if (({rem_next, 1'b0} >= {2'b00, cur_a}) && (quo_next != INV_W'(SAT_VAL)))
            fin_q = quo_next + 1'b1;
`endif
        ch_result = sat_cur ? INV_W'(SAT_VAL) : fin_q;
    end

    // Sequencer and datapath registers; outputs change only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ch       <= '0;
            it_cnt   <= '0;
            a_cap    <= '0;
            rem      <= '0;
            quo      <= '0;
            sat_cur  <= 1'b0;
            res_hold <= '0;
            sat_hold <= '0;
            Inv_AR   <= '0;
            Inv_AG   <= '0;
            Inv_AB   <= '0;
            div_sat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_cap <= {A_B, A_G, A_R};
                        ch    <= 2'd0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Saturated channels still iterate so latency stays fixed; a zero
                    // remainder keeps the step harmless for tiny or zero divisors.
                    sat_cur <= is_sat(cur_a);
                    rem     <= is_sat(cur_a) ? '0 : REM_W'(REM_INIT);
                    quo     <= '0;
                    it_cnt  <= '0;
                    state   <= ITER;
                end
                ITER: begin
                    rem    <= rem_next;
                    quo    <= quo_next;
                    it_cnt <= it_cnt + 4'd1;
                    if (it_cnt == 4'(DIV_ITERS - 1)) begin
                        if (ch == 2'd2) begin
                            Inv_AR  <= res_hold[0];
                            Inv_AG  <= res_hold[1];
                            Inv_AB  <= ch_result;
                            div_sat <= {sat_hold[0], sat_hold[1], sat_cur};
                            state   <= DONE;
                        end else begin
                            res_hold[ch[0]] <= ch_result;
                            sat_hold[ch[0]] <= sat_cur;
                            ch              <= ch + 2'd1;
                            state           <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_atm_light_te.sv
// Directed bench for inv_atm_light_te. Latency is counted with the accepting edge
// as edge 1, so done must first be seen after edge 34.
module tb_inv_atm_light_te;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A_R = '0, A_G = '0, A_B = '0;
    logic [9:0] Inv_AR, Inv_AG, Inv_AB;
    logic       busy, done;
    logic [2:0] div_sat;

    int n_chk  = 0;
    int n_fail = 0;

    inv_atm_light_te dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A_R     (A_R),
        .A_G     (A_G),
        .A_B     (A_B),
        .Inv_AR  (Inv_AR),
        .Inv_AG  (Inv_AG),
        .Inv_AB  (Inv_AB),
        .busy    (busy),
        .done    (done),
        .div_sat (div_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request, wait for done (bounded), return edges counted from acceptance.
    task automatic run(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input bit scramble, output int lat);
        @(negedge clk);
        A_R = r; A_G = g; A_B = b;
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (scramble) begin
                A_R = 8'($urandom); A_G = 8'($urandom); A_B = 8'($urandom);
            end
            if (done || lat >= 60) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic chk_res(input string tag, input int lat, input int er, input int eg,
                           input int eb, input int es);
        chk({tag, "_lat"}, lat, 34);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_r"}, Inv_AR, er);
        chk({tag, "_g"}, Inv_AG, eg);
        chk({tag, "_b"}, Inv_AB, eb);
        chk({tag, "_sat"}, div_sat, es);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int lat;
        int exp_b200;
        int n_done, d1, d2, n_blow, blow_pos;
`ifdef INV_AC_ROUND_EN
        exp_b200 = 328;
`else
        exp_b200 = 327;
`endif
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r", Inv_AR, 0);
        chk("rst_g", Inv_AG, 0);
        chk("rst_b", Inv_AB, 0);
        chk("rst_sat", div_sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // nominal values
        run(8'd255, 8'd128, 8'd200, 1'b0, lat);
        chk_res("nom", lat, 257, 512, exp_b200, 0);

        // saturation and zero divisor
        run(8'd64, 8'd0, 8'd65, 1'b0, lat);
        chk_res("sat", lat, 1023, 1023, 1008, 3'b110);

        // start held 80 edges window: first 40 with start high
        @(negedge clk);
        A_R = 8'd255; A_G = 8'd128; A_B = 8'd200;
        start = 1'b1;
        n_done = 0; d1 = 0; d2 = 0; n_blow = 0; blow_pos = 0;
        for (int p = 1; p <= 80; p++) begin
            @(posedge clk);
            @(negedge clk);
            if (p == 40) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) d1 = p; else d2 = p;
            end
            if (!busy && p < 69) begin
                n_blow++;
                blow_pos = p;
            end
        end
        chk("hold_ndone", n_done, 2);
        chk("hold_d1", d1, 34);
        chk("hold_d2", d2, 69);
        chk("hold_idle_cycles", n_blow, 1);
        chk("hold_idle_pos", blow_pos, 35);
        chk("hold_r", Inv_AR, 257);
        chk("hold_b", Inv_AB, exp_b200);

        // reset mid-run
        @(negedge clk);
        A_R = 8'd10; A_G = 8'd20; A_B = 8'd30;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_r", Inv_AR, 0);
        chk("mrst_g", Inv_AG, 0);
        chk("mrst_b", Inv_AB, 0);
        chk("mrst_sat", div_sat, 0);
        chk("mrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int p = 0; p < 40; p++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("mrst_nodone", n_done, 0);
        run(8'd100, 8'd100, 8'd100, 1'b0, lat);
        chk_res("post_rst", lat, 655, 655, 655, 0);

        // inputs change every cycle while busy
        run(8'd255, 8'd128, 8'd200, 1'b1, lat);
        chk_res("scram", lat, 257, 512, exp_b200, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
